if_fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the next-PC logic.
- Owns the fetch PC and issues single-outstanding requests to instruction memory over a req/ack handshake.
- Buffers returned {pc, inst} pairs in a small FIFO toward IF/ID.
- Takes redirects (jump/branch/jr target plus a jump flag) from the next-PC stage, then flushes and refetches.

---
 rtl/if_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage with a single outstanding imem
// request and a small {pc, inst} FIFO toward IF/ID. Redirects flush the
// FIFO and cause any in-flight response to be discarded.
// Optional build macro: FETCH_PERF_EN adds perf_redirects / perf_drops.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_drops
`endif
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt, addr_nxt, redirect_tgt;
  logic          push, pop;
  logic [CW-1:0] count, count_nxt, count_after_pop;
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [31:0]   mem_pc   [FIFO_DEPTH];
  logic [31:0]   mem_inst [FIFO_DEPTH];

  assign redirect_tgt    = redirect_pc & ~32'h3;
  assign pop             = inst_valid & inst_ready;
  assign push            = (state == S_WAIT) & imem_ack & ~redirect_valid;
  assign count_nxt       = count + CW'(push) - CW'(pop);
  assign count_after_pop = count - CW'(pop);
  assign rd_ptr_nxt      = rd_ptr + PW'(pop);

  // Fetch state, fetch PC and registered request outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      imem_req  <= (state_nxt != S_IDLE);
      imem_addr <= addr_nxt;
    end
  end

  // Next-state, next fetch PC and next request address
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    addr_nxt     = imem_addr;
    case (state)
      S_IDLE: begin
        if (redirect_valid) begin
          fetch_pc_nxt = redirect_tgt;
        end else if (count_nxt < CW'(FIFO_DEPTH)) begin
          state_nxt = S_WAIT;
          addr_nxt  = fetch_pc;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          if (!redirect_valid) begin
            fetch_pc_nxt = imem_addr + 32'd4;
            if (count_nxt < CW'(FIFO_DEPTH)) begin
              addr_nxt = imem_addr + 32'd4;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            fetch_pc_nxt = redirect_tgt;
            state_nxt    = S_IDLE;
          end
        end else if (redirect_valid) begin
          fetch_pc_nxt = redirect_tgt;
          state_nxt    = S_DROP;
        end
      end
      S_DROP: begin
        if (redirect_valid) fetch_pc_nxt = redirect_tgt;
        if (imem_ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage; data entries need no reset since count gates validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= imem_addr;
      mem_inst[wr_ptr] <= imem_rdata;
    end
  end

  // FIFO pointers, occupancy and registered head outputs; flush wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      inst_valid <= 1'b0;
      inst_pc    <= 32'd0;
      inst       <= 32'd0;
    end else if (redirect_valid) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      inst_valid <= 1'b0;
    end else begin
      count      <= count_nxt;
      rd_ptr     <= rd_ptr_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      inst_valid <= (count_nxt != '0);
      if (count_after_pop == '0) begin
        if (push) begin
          inst_pc <= imem_addr;
          inst    <= imem_rdata;
        end
      end else begin
        inst_pc <= mem_pc[rd_ptr_nxt];
        inst    <= mem_inst[rd_ptr_nxt];
      end
    end
  end

  // A push into a full FIFO cannot happen: WAIT is only entered with room
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && (count == CW'(FIFO_DEPTH))));
  end

`ifdef FETCH_PERF_EN
  logic drop;
  assign drop = imem_ack & ((state == S_DROP) | ((state == S_WAIT) & redirect_valid));

  // Redirect and discarded-response event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_redirects <= 32'd0;
      perf_drops     <= 32'd0;
    end else begin
      if (redirect_valid) perf_redirects <= perf_redirects + 32'd1;
      if (drop)           perf_drops     <= perf_drops + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_drops;
  int unsigned m_redirs = 0;
  int unsigned m_drops  = 0;
`endif

  if_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst(inst)
`ifdef FETCH_PERF_EN
    , .perf_redirects(perf_redirects), .perf_drops(perf_drops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: outstanding flag, keep-or-discard flag, fetch PC, queue
  bit          m_out  = 1'b0;
  bit          m_keep = 1'b0;
  logic [31:0] m_addr = RESET_PC;
  logic [31:0] m_pc   = RESET_PC;
  logic [63:0] q[$];

  initial begin
    logic [31:0] tgt;
    bit p, got, keep;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_out = 1'b0; m_keep = 1'b0; m_addr = RESET_PC; m_pc = RESET_PC;
        q.delete();
`ifdef FETCH_PERF_EN
        m_redirs = 0; m_drops = 0;
`endif
      end else begin
        tgt  = redirect_pc & ~32'h3;
        p    = (q.size() != 0) && inst_ready;
        got  = m_out && imem_ack;
        keep = got && m_keep && !redirect_valid;
`ifdef FETCH_PERF_EN
        if (redirect_valid) m_redirs++;
        if (got && !keep) m_drops++;
`endif
        if (redirect_valid) q.delete();
        else begin
          if (p) void'(q.pop_front());
          if (keep) q.push_back({m_addr, imem_rdata});
        end
        if (!m_out) begin
          if (redirect_valid) m_pc = tgt;
          else if (q.size() < DEPTH) begin
            m_out = 1'b1; m_keep = 1'b1; m_addr = m_pc;
          end
        end else if (!imem_ack) begin
          if (redirect_valid) begin m_keep = 1'b0; m_pc = tgt; end
        end else if (keep) begin
          m_pc = m_addr + 32'd4;
          if (q.size() < DEPTH) m_addr = m_addr + 32'd4;
          else m_out = 1'b0;
        end else begin
          if (redirect_valid) m_pc = tgt;
          m_out = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare of DUT outputs against the model
  initial begin
    logic [63:0] h;
    forever begin
      @(negedge clk);
      chk("imem_req", 32'(imem_req), 32'(m_out));
      if (m_out) chk("imem_addr", imem_addr, m_addr);
      chk("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        h = q[0];
        chk("inst_pc", inst_pc, h[63:32]);
        chk("inst", inst, h[31:0]);
      end
`ifdef FETCH_PERF_EN
      chk("perf_redirects", perf_redirects, m_redirs);
      chk("perf_drops", perf_drops, m_drops);
`endif
    end
  end

  // Memory responder: ack after 'lat' request cycles, rdata = addr or random
  int lat = 1;
  int wcnt = 0;
  bit rand_mode = 1'b0;
  bit rdata_addr = 1'b1;

  task automatic mem_resp();
    if (imem_req) begin
      wcnt++;
      if (wcnt >= lat) begin
        imem_ack = 1'b1;
        wcnt = 0;
        if (rand_mode) lat = $urandom_range(1, 3);
      end else imem_ack = 1'b0;
    end else begin
      wcnt = 0;
      imem_ack = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    imem_rdata = rdata_addr ? imem_addr : $urandom;
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
    mem_resp();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1; imem_ack = 1'b0; redirect_valid = 1'b0; wcnt = 0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst", inst, 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b1;

    // Zero-wait streaming from reset
    lat = 1; rdata_addr = 1'b1; inst_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      nxt();
      chk("t1_req", 32'(imem_req), 32'd1);
      chk("t1_addr", imem_addr, RESET_PC + 32'(4 * k));
      if (k > 0) begin
        chk("t1_valid", 32'(inst_valid), 32'd1);
        chk("t1_pc", inst_pc, RESET_PC + 32'(4 * (k - 1)));
        chk("t1_inst", inst, RESET_PC + 32'(4 * (k - 1)));
      end
    end

    // Backpressure: two entries buffered then idle, then drain and resume
    inst_ready = 1'b0;
    do_reset();
    repeat (4) nxt();
    chk("t2_req_idle", 32'(imem_req), 32'd0);
    chk("t2_valid", 32'(inst_valid), 32'd1);
    chk("t2_head0", inst_pc, 32'hBFC0_0000);
    inst_ready = 1'b1;
    nxt();
    chk("t2_head1", inst_pc, 32'hBFC0_0004);
    chk("t2_resume_req", 32'(imem_req), 32'd1);
    chk("t2_resume_addr", imem_addr, 32'hBFC0_0008);
    nxt();
    chk("t2_head2", inst_pc, 32'hBFC0_0008);

    // 3-cycle memory, redirect during the first wait cycle
    lat = 3;
    do_reset();
    nxt();
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0000;
    nxt();
    redirect_valid = 1'b0;
    chk("t3_drop_req", 32'(imem_req), 32'd1);
    nxt();
    nxt();
    chk("t3_idle_req", 32'(imem_req), 32'd0);
    chk("t3_valid", 32'(inst_valid), 32'd0);
`ifdef FETCH_PERF_EN
    chk("t3_perf_r", perf_redirects, 32'd1);
    chk("t3_perf_d", perf_drops, 32'd1);
`endif
    nxt();
    chk("t3_addr", imem_addr, 32'h0040_0000);
    repeat (6) nxt();

    // Redirect together with ack and pop while one entry is buffered
    lat = 1; inst_ready = 1'b1;
    do_reset();
    nxt();
    nxt();
    chk("t4_one_entry", 32'(inst_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0010;
    nxt();
    redirect_valid = 1'b0;
    chk("t4_flushed", 32'(inst_valid), 32'd0);
    nxt();
    chk("t4_addr", imem_addr, 32'h0040_0010);
    nxt();
    chk("t4_pc", inst_pc, 32'h0040_0010);

    // Unaligned redirect target is forced to word alignment
    do_reset();
    nxt();
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0013;
    nxt();
    redirect_valid = 1'b0;
`ifdef FETCH_PERF_EN
    chk("t5_perf_r", perf_redirects, 32'd1);
    chk("t5_perf_d", perf_drops, 32'd1);
`endif
    nxt();
    chk("t5_align", imem_addr, 32'h0040_0010);

    // PC wrap at the top of the address space
    do_reset();
    nxt();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    nxt();
    redirect_valid = 1'b0;
    nxt();
    chk("t5_top", imem_addr, 32'hFFFF_FFFC);
    nxt();
    chk("t5_wrap", imem_addr, 32'h0000_0000);
    chk("t5_wrap_pc", inst_pc, 32'hFFFF_FFFC);

    // Reset asserted with a request outstanding
    lat = 3;
    do_reset();
    nxt();
    chk("t6_wait", 32'(imem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_req", 32'(imem_req), 32'd0);
    chk("t6_valid", 32'(inst_valid), 32'd0);
    chk("t6_addr", imem_addr, RESET_PC);
`ifdef FETCH_PERF_EN
    chk("t6_perf_r", perf_redirects, 32'd0);
    chk("t6_perf_d", perf_drops, 32'd0);
`endif
    nxt();
    imem_ack = 1'b1;
    nxt();
    imem_ack = 1'b1;
    rst = 1'b0;
    nxt();
    chk("t6_first_req", 32'(imem_req), 32'd1);
    chk("t6_first_addr", imem_addr, RESET_PC);

    // Randomized traffic
    rand_mode = 1'b1; rdata_addr = 1'b0; lat = 2;
    for (int i = 0; i < 3000; i++) begin
      nxt();
      inst_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
      if (i == 1500) begin
        redirect_valid = 1'b0;
        rst = 1'b1;
        nxt();
        rst = 1'b0;
      end
    end
    redirect_valid = 1'b0;
    nxt();
    nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
